pixel_block_loader: RTL and testbench

Streams 8-bit integer pixels into a 15x15 reference block and presents it as the flat 1800-bit `integer_array` bus used by the sub-pixel interpolation input mux. It sits directly upstream of `input_array_mux`. It converts a raster pixel stream with valid/ready flow control into a whole-block handoff with valid/ack.

---
 rtl/pixel_block_loader.sv | 125 ++++++++++++
 tb/tb_pixel_block_loader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_block_loader.sv
// pixel_block_loader: packs a raster pixel stream into a BLK_W x BLK_H block bus handed off with valid/ack.
// Build option PIXEL_BLOCK_LOADER_PINGPONG_EN: two banks (fill one while presenting the other); undefined = one bank.
module pixel_block_loader #(
    parameter int BLK_W = 15,
    parameter int BLK_H = 15,
    parameter int PIX_W = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [PIX_W-1:0]               pix_in,
    input  logic                           pix_valid,
    input  logic                           pix_sof,
    output logic                           pix_ready,
    output logic [BLK_W*BLK_H*PIX_W-1:0]   integer_array,
    output logic                           block_valid,
    input  logic                           block_ack,
    output logic                           sync_err,
    output logic [1:0]                     dbg_rd_state
);

    // Handshakes: a pixel moves on a clock edge with pix_valid && pix_ready (pix_ready is registered);
    // a block is held stable while block_valid is high and is released on the edge with block_valid && block_ack.

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_t;

    localparam int BLK_BITS = BLK_W * BLK_H * PIX_W;
`ifdef PIXEL_BLOCK_LOADER_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    logic [BLK_BITS-1:0] bank_mem [NB];
    bank_state_t         st_q [NB];
    bank_state_t         st_d [NB];
    logic [3:0]          row_q, col_q, row_d, col_d;
    logic [3:0]          wr_row, wr_col;
    logic                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                ready_d;
    logic                beat, resync, last_pix, release_blk;
    int                  wr_off;

    assign block_valid   = (st_q[rd_ptr_q] == BANK_FULL);
    assign integer_array = bank_mem[rd_ptr_q];
    assign dbg_rd_state  = st_q[rd_ptr_q];

    always_comb begin
        beat        = pix_valid && pix_ready;
        resync      = beat && pix_sof && ((row_q != 4'd0) || (col_q != 4'd0));
        // A resync beat lands at (0,0) and the partial block behind it is simply overwritten.
        wr_row      = resync ? 4'd0 : row_q;
        wr_col      = resync ? 4'd0 : col_q;
        last_pix    = beat && (wr_row == 4'(BLK_H - 1)) && (wr_col == 4'(BLK_W - 1));
        release_blk = block_valid && block_ack;
        wr_off      = (int'(wr_row) * BLK_W + int'(wr_col)) * PIX_W;

        for (int b = 0; b < NB; b++) st_d[b] = st_q[b];
        row_d    = row_q;
        col_d    = col_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        if (release_blk) begin
            st_d[rd_ptr_q] = BANK_EMPTY;
`ifdef PIXEL_BLOCK_LOADER_PINGPONG_EN
            // Blocks alternate banks strictly, so the next block to present is always in the other bank.
            rd_ptr_d = ~rd_ptr_q;
`endif
        end

        if (beat) begin
            if (last_pix) begin
                st_d[wr_ptr_q] = BANK_FULL;
                row_d          = 4'd0;
                col_d          = 4'd0;
`ifdef PIXEL_BLOCK_LOADER_PINGPONG_EN
                wr_ptr_d       = ~wr_ptr_q;
`endif
            end else begin
                st_d[wr_ptr_q] = BANK_FILLING;
                if (wr_col == 4'(BLK_W - 1)) begin
                    col_d = 4'd0;
                    row_d = wr_row + 4'd1;
                end else begin
                    col_d = wr_col + 4'd1;
                    row_d = wr_row;
                end
            end
        end

        ready_d = 1'b0;
        for (int b = 0; b < NB; b++) begin
            if (st_d[b] != BANK_FULL) ready_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            row_q     <= 4'd0;
            col_q     <= 4'd0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            pix_ready <= 1'b1;
            sync_err  <= 1'b0;
            for (int b = 0; b < NB; b++) begin
                st_q[b]     <= BANK_EMPTY;
                bank_mem[b] <= '0;
            end
        end else begin
            row_q     <= row_d;
            col_q     <= col_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            pix_ready <= ready_d;
            sync_err  <= resync;
            for (int b = 0; b < NB; b++) st_q[b] <= st_d[b];
            if (beat) bank_mem[wr_ptr_q][wr_off +: PIX_W] <= pix_in;
        end
    end

endmodule

// File: tb/tb_pixel_block_loader.sv
// Directed bench for pixel_block_loader: reset, ramp block, backpressure or ping-pong, resync, mid-block reset.
module tb_pixel_block_loader;

    localparam int BITS = 1800;
    localparam int NPIX = 225;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [7:0]      pix_in = 8'd0;
    logic            pix_valid = 1'b0;
    logic            pix_sof = 1'b0;
    logic            pix_ready;
    logic [BITS-1:0] integer_array;
    logic            block_valid;
    logic            block_ack = 1'b0;
    logic            sync_err;
    logic [1:0]      dbg_rd_state;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;
    logic [BITS-1:0] exp_q[$];

    pixel_block_loader dut (
        .clock         (clock),
        .reset         (reset),
        .pix_in        (pix_in),
        .pix_valid     (pix_valid),
        .pix_sof       (pix_sof),
        .pix_ready     (pix_ready),
        .integer_array (integer_array),
        .block_valid   (block_valid),
        .block_ack     (block_ack),
        .sync_err      (sync_err),
        .dbg_rd_state  (dbg_rd_state)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (sync_err) err_pulses = err_pulses + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic int first_diff(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
        for (int i = 0; i < NPIX; i++) begin
            if (a[i*8 +: 8] !== b[i*8 +: 8]) return i;
        end
        return 0;
    endfunction

    // Presents one pixel from a falling edge and returns on the falling edge after it was accepted.
    task automatic send_pix(input logic [7:0] v, input logic sof);
        int waitc = 0;
        pix_in    = v;
        pix_sof   = sof;
        pix_valid = 1'b1;
        while (!pix_ready && waitc < 2000) begin
            @(negedge clock);
            waitc++;
        end
        if (!pix_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout pix_ready got %b exp 1", pix_ready);
        end
        @(negedge clock);
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic ack_pulse();
        block_ack = 1'b1;
        @(negedge clock);
        block_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        checks++; if (pix_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", pix_ready); end
        checks++; if (block_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", block_valid); end
        checks++; if (integer_array !== '0) begin errors++; $display("FAIL rst_array byte %0d nonzero", first_diff(integer_array, '0)); end
        checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL rst_sync_err got %b exp 0", sync_err); end
        checks++; if (dbg_rd_state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", dbg_rd_state); end
    endtask

    task automatic test_ramp();
        logic exp_rdy;
        for (int k = 0; k < NPIX; k++) send_pix(8'(k), k == 0);
`ifdef PIXEL_BLOCK_LOADER_PINGPONG_EN
        exp_rdy = 1'b1;
`else
        exp_rdy = 1'b0;
`endif
        checks++; if (block_valid !== 1'b1) begin errors++; $display("FAIL ramp_valid got %b exp 1", block_valid); end
        checks++; if (integer_array[7:0] !== 8'h00) begin errors++; $display("FAIL ramp_b0 got %h exp 00", integer_array[7:0]); end
        checks++; if (integer_array[15:8] !== 8'h01) begin errors++; $display("FAIL ramp_b1 got %h exp 01", integer_array[15:8]); end
        checks++; if (integer_array[127:120] !== 8'h0F) begin errors++; $display("FAIL ramp_r1c0 got %h exp 0f", integer_array[127:120]); end
        checks++; if (integer_array[1799:1792] !== 8'hE0) begin errors++; $display("FAIL ramp_last got %h exp e0", integer_array[1799:1792]); end
        checks++; if (pix_ready !== exp_rdy) begin errors++; $display("FAIL ramp_ready got %b exp %b", pix_ready, exp_rdy); end
        ack_pulse();
        checks++; if (block_valid !== 1'b0) begin errors++; $display("FAIL ramp_release got %b exp 0", block_valid); end
        checks++; if (pix_ready !== 1'b1) begin errors++; $display("FAIL ramp_ready_after got %b exp 1", pix_ready); end
    endtask

`ifndef PIXEL_BLOCK_LOADER_PINGPONG_EN
    task automatic test_backpressure();
        logic [BITS-1:0] exp_a, exp_b;
        for (int k = 0; k < NPIX; k++) begin
            exp_a[k*8 +: 8] = 8'(k * 7 + 3);
            exp_b[k*8 +: 8] = 8'(k) ^ 8'h5A;
        end
        for (int k = 0; k < NPIX; k++) send_pix(exp_a[k*8 +: 8], k == 0);
        fork
            begin
                for (int k = 0; k < NPIX; k++) send_pix(exp_b[k*8 +: 8], k == 0);
            end
            begin
                repeat (20) @(negedge clock);
                checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low got %b exp 0", pix_ready); end
                checks++; if (block_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_hold got %b exp 1", block_valid); end
                checks++;
                if (integer_array !== exp_a) begin
                    errors++;
                    $display("FAIL bp_hold_data byte %0d got %h exp %h", first_diff(integer_array, exp_a),
                             integer_array[first_diff(integer_array, exp_a)*8 +: 8], exp_a[first_diff(integer_array, exp_a)*8 +: 8]);
                end
                ack_pulse();
                checks++; if (pix_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_return got %b exp 1", pix_ready); end
            end
        join
        checks++; if (block_valid !== 1'b1) begin errors++; $display("FAIL bp_second_valid got %b exp 1", block_valid); end
        checks++;
        if (integer_array !== exp_b) begin
            errors++;
            $display("FAIL bp_second_data byte %0d got %h exp %h", first_diff(integer_array, exp_b),
                     integer_array[first_diff(integer_array, exp_b)*8 +: 8], exp_b[first_diff(integer_array, exp_b)*8 +: 8]);
        end
        ack_pulse();
    endtask
`else
    task automatic test_pingpong();
        logic [BITS-1:0] blk;
        int got = 0;
        int stall_bad = 0;
        int saw_stall = 0;
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < NPIX; k++) blk[k*8 +: 8] = 8'(b * 50 + k);
            exp_q.push_back(blk);
        end
        fork
            begin
                for (int b = 0; b < 3; b++) begin
                    for (int k = 0; k < NPIX; k++) send_pix(8'(b * 50 + k), k == 0);
                end
            end
            begin
                int dly = 0;
                int cyc = 0;
                // The first block is held long enough for the second to complete, forcing a both-full stall.
                while (got < 3 && cyc < 5000) begin
                    @(negedge clock);
                    cyc++;
                    if (!pix_ready && !block_valid) stall_bad++;
                    if (!pix_ready) saw_stall = 1;
                    if (block_valid) begin
                        dly++;
                        if (dly >= ((got == 0) ? 240 : 10)) begin
                            blk = exp_q.pop_front();
                            checks++;
                            if (integer_array !== blk) begin
                                errors++;
                                $display("FAIL pp_block%0d byte %0d got %h exp %h", got, first_diff(integer_array, blk),
                                         integer_array[first_diff(integer_array, blk)*8 +: 8], blk[first_diff(integer_array, blk)*8 +: 8]);
                            end
                            ack_pulse();
                            cyc++;
                            if (got == 0) begin
                                checks++;
                                if (block_valid !== 1'b1) begin errors++; $display("FAIL pp_switch_valid got %b exp 1", block_valid); end
                            end
                            got++;
                            dly = 0;
                        end
                    end else begin
                        dly = 0;
                    end
                end
            end
        join
        checks++; if (got !== 3) begin errors++; $display("FAIL pp_block_count got %0d exp 3", got); end
        checks++; if (stall_bad !== 0) begin errors++; $display("FAIL pp_ready_low_not_full got %0d exp 0", stall_bad); end
        checks++; if (saw_stall !== 1) begin errors++; $display("FAIL pp_both_full_stall got %0d exp 1", saw_stall); end
    endtask
`endif

    task automatic test_resync();
        logic [BITS-1:0] blk;
        int base = err_pulses;
        blk[7:0] = 8'hAA;
        for (int j = 0; j < NPIX - 1; j++) blk[(j+1)*8 +: 8] = 8'(100 + j);
        for (int k = 0; k < 40; k++) send_pix(8'(k + 1), k == 0);
        checks++; if (block_valid !== 1'b0) begin errors++; $display("FAIL rs_partial_valid got %b exp 0", block_valid); end
        send_pix(8'hAA, 1'b1);
        for (int j = 0; j < NPIX - 1; j++) send_pix(8'(100 + j), 1'b0);
        checks++; if (block_valid !== 1'b1) begin errors++; $display("FAIL rs_valid got %b exp 1", block_valid); end
        checks++; if (integer_array[7:0] !== 8'hAA) begin errors++; $display("FAIL rs_byte0 got %h exp aa", integer_array[7:0]); end
        checks++;
        if (integer_array !== blk) begin
            errors++;
            $display("FAIL rs_block byte %0d got %h exp %h", first_diff(integer_array, blk),
                     integer_array[first_diff(integer_array, blk)*8 +: 8], blk[first_diff(integer_array, blk)*8 +: 8]);
        end
        ack_pulse();
        repeat (20) @(negedge clock);
        checks++; if (block_valid !== 1'b0) begin errors++; $display("FAIL rs_single_block got %b exp 0", block_valid); end
        checks++; if (err_pulses - base !== 1) begin errors++; $display("FAIL rs_sync_err_cycles got %0d exp 1", err_pulses - base); end
    endtask

    task automatic test_mid_reset();
        logic [BITS-1:0] blk;
        int base = err_pulses;
        for (int k = 0; k < NPIX; k++) blk[k*8 +: 8] = 8'(k * 3);
        for (int k = 0; k < 100; k++) send_pix(8'(255 - k), k == 0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++; if (block_valid !== 1'b0) begin errors++; $display("FAIL mr_valid got %b exp 0", block_valid); end
        checks++; if (pix_ready !== 1'b1) begin errors++; $display("FAIL mr_ready got %b exp 1", pix_ready); end
        checks++; if (integer_array !== '0) begin errors++; $display("FAIL mr_array byte %0d nonzero", first_diff(integer_array, '0)); end
        for (int k = 0; k < NPIX; k++) send_pix(blk[k*8 +: 8], k == 0);
        checks++; if (block_valid !== 1'b1) begin errors++; $display("FAIL mr_block_valid got %b exp 1", block_valid); end
        checks++;
        if (integer_array !== blk) begin
            errors++;
            $display("FAIL mr_block byte %0d got %h exp %h", first_diff(integer_array, blk),
                     integer_array[first_diff(integer_array, blk)*8 +: 8], blk[first_diff(integer_array, blk)*8 +: 8]);
        end
        ack_pulse();
        repeat (5) @(negedge clock);
        checks++; if (block_valid !== 1'b0) begin errors++; $display("FAIL mr_single_block got %b exp 0", block_valid); end
        checks++; if (err_pulses - base !== 0) begin errors++; $display("FAIL mr_sync_err got %0d exp 0", err_pulses - base); end
    endtask

    initial begin
        test_reset();
        test_ramp();
`ifdef PIXEL_BLOCK_LOADER_PINGPONG_EN
        test_pingpong();
`else
        test_backpressure();
`endif
        test_resync();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
